slot_reel_gen: RTL and testbench

- Upstream stage of the slot-machine game: produces the nine 2-bit symbols (box1..box9) that the display/scoring block consumes.
- On a start pulse it spins the reels, refreshing spinning symbols from a free-running LFSR on a slow tick.
- Columns stop left to right after programmable delays, then it pulses done with a stable 3x3 result.
- This replaces the non-synthesizable random source in the game top level.

---
 rtl/slot_reel_gen_if.sv | 16 +
 rtl/slot_reel_gen.sv | 101 ++++++++++
 tb/tb_slot_reel_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/slot_reel_gen_if.sv
// slot_reel_gen_if: reel generator handshake/result bus; stop_req exists only with SLOT_EARLY_STOP_EN
interface slot_reel_gen_if;
    logic        start;
    logic [17:0] boxes;
    logic [2:0]  col_stopped;
    logic        busy;
    logic        done;
`ifdef SLOT_EARLY_STOP_EN
    logic        stop_req;
    modport master(output start, stop_req, input boxes, col_stopped, busy, done);
    modport slave(input start, stop_req, output boxes, col_stopped, busy, done);
`else
    modport master(output start, input boxes, col_stopped, busy, done);
    modport slave(input start, output boxes, col_stopped, busy, done);
`endif
endinterface

// File: rtl/slot_reel_gen.sv
// slot_reel_gen: LFSR-driven 3x3 reel spinner; early column stop enabled by SLOT_EARLY_STOP_EN
module slot_reel_gen #(
    parameter int          TICK_DIV   = 1000000,
    parameter int          SPIN_TICKS = 20,
    parameter int          STOP_GAP   = 4,
    parameter logic [31:0] SEED       = 32'hACE1_2024
) (
    input logic            clk,
    input logic            rst_n,
    slot_reel_gen_if.slave bus
);
    localparam int              CW      = $clog2(TICK_DIV);
    localparam int              NW      = $clog2(SPIN_TICKS + 3 * STOP_GAP + 1);
    localparam logic [31:0]     MASK    = 32'h8020_0003;
    localparam logic [31:0]     SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SPIN, DONE} state_t;

    state_t        state;
    logic [31:0]   lfsr;
    logic [CW-1:0] tick_cnt;
    logic [NW-1:0] tick_num;
    logic [NW-1:0] stop_at;
    logic [NW-1:0] n_next;
    logic [17:0]   fresh;
    logic [2:0]    stop_next;
    logic          tick;
    logic          stop_now;
    logic          pend;

    for (genvar k = 0; k < 9; k++) begin : g_sym
        assign fresh[2*k +: 2] = lfsr[2*k +: 2] + 2'd1;
    end

    // Free-running Galois LFSR; a nonzero state can never shift to zero
    always_ff @(posedge clk)
        if (!rst_n) lfsr <= SEED_NZ;
        else lfsr <= lfsr[0] ? (lfsr >> 1) ^ MASK : lfsr >> 1;

    // Tick detection; a column stops on its scheduled tick or on a pending early stop
    always_comb begin
        tick      = (state == SPIN) && (tick_cnt == CNT_MAX);
        n_next    = tick_num + 1'b1;
        stop_now  = tick && ((n_next == stop_at) || pend);
        stop_next = {bus.col_stopped[1:0], 1'b1};
    end

`ifdef SLOT_EARLY_STOP_EN
    // Pending early-stop request, consumed by the next tick
    always_ff @(posedge clk)
        if (!rst_n || state != SPIN) pend <= 1'b0;
        else pend <= tick ? bus.stop_req : (pend | bus.stop_req);
`else
    assign pend = 1'b0;
`endif

    // Reel FSM: stop_at tracks the next stop tick so an early stop shifts later stops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            tick_num        <= '0;
            stop_at         <= '0;
            bus.boxes       <= '0;
            bus.col_stopped <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state           <= SPIN;
                    tick_cnt        <= '0;
                    tick_num        <= '0;
                    stop_at         <= NW'(SPIN_TICKS);
                    bus.col_stopped <= '0;
                    bus.busy        <= 1'b1;
                end
                SPIN: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick) begin
                        tick_num <= n_next;
                        for (int c = 0; c < 3; c++)
                            if (!bus.col_stopped[c]) bus.boxes[6*c +: 6] <= fresh[6*c +: 6];
                    end
                    if (stop_now) begin
                        bus.col_stopped <= stop_next;
                        stop_at         <= n_next + NW'(STOP_GAP);
                        if (stop_next[2]) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slot_reel_gen.sv
// tb_slot_reel_gen: directed checks of spin timing, results, ignored starts and reset
module tb_slot_reel_gen;
    localparam logic [31:0] SEED = 32'hACE1_2024;
    localparam int          ST   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m_lfsr;
    logic [17:0] exp_boxes = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    slot_reel_gen_if bus();

    slot_reel_gen #(.TICK_DIV(4), .SPIN_TICKS(ST), .STOP_GAP(2), .SEED(SEED)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Reference LFSR x^32+x^22+x^2+x+1, Galois right-shift form
    always @(posedge clk)
        m_lfsr <= !rst_n ? SEED : (m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1));

    function automatic logic [17:0] sym(input logic [31:0] l);
        logic [17:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[2*i +: 2] = l[2*i +: 2] + 2'd1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; start is sampled at the next edge E, column c stops at tick s0+2c
    task automatic run(input int s0, input bit poke);
        int          kd;
        int          n;
        logic [17:0] fr;
        logic [2:0]  cs;
        kd = 4 * (s0 + 4);
        cs = 3'b000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= kd + 1; k++) begin
            bus.start = poke && (k == 5 || k == kd + 1);
`ifdef SLOT_EARLY_STOP_EN
            bus.stop_req = (s0 < ST) && (k == 2);
`endif
            fr = sym(m_lfsr);
            @(negedge clk);
            bus.start = 1'b0;
`ifdef SLOT_EARLY_STOP_EN
            bus.stop_req = 1'b0;
`endif
            if (k % 4 == 0 && k <= kd) begin
                n = k / 4;
                for (int c = 0; c < 3; c++)
                    if (!cs[c]) exp_boxes[6*c +: 6] = fr[6*c +: 6];
                cs = {n >= s0 + 4, n >= s0 + 2, n >= s0};
                check("boxes_tick", 32'(bus.boxes), 32'(exp_boxes));
            end
            check("col_stopped", 32'(bus.col_stopped), 32'(cs));
            check("busy", 32'(bus.busy), 32'(k < kd));
            check("done", 32'(bus.done), 32'(k == kd));
        end
    endtask

    initial begin
        bus.start = 1'b0;
`ifdef SLOT_EARLY_STOP_EN
        bus.stop_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_boxes", 32'(bus.boxes), 32'd0);
        check("rst_cols", 32'(bus.col_stopped), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_lfsr", dut.lfsr, SEED);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("lfsr_seq", dut.lfsr, m_lfsr);

        run(ST, 1'b0);
        repeat (1000) @(negedge clk);
        check("idle_hold", 32'(bus.boxes), 32'(exp_boxes));
        check("idle_cols", 32'(bus.col_stopped), 32'b111);

        run(ST, 1'b1);
        run(ST, 1'b0);

        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_boxes", 32'(bus.boxes), 32'd0);
        check("mid_rst_cols", 32'(bus.col_stopped), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_lfsr", dut.lfsr, SEED);
        rst_n = 1'b1;
        exp_boxes = '0;
        run(ST, 1'b0);
        check("lfsr_after", dut.lfsr, m_lfsr);

`ifdef SLOT_EARLY_STOP_EN
        bus.stop_req = 1'b1;
        @(negedge clk);
        bus.stop_req = 1'b0;
        run(ST, 1'b0);
        run(1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
